// File: rtl/temporizador_pkg.sv
// temporizador_pkg: shared definitions for the door-open timer.
//   estado_t    : FSM state encoding (IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3)
//   presc_width : width of a prescaler counting 0..clk_hz-1
package temporizador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } estado_t;

  function automatic int presc_width(input int clk_hz);
    return (clk_hz > 1) ? $clog2(clk_hz) : 1;
  endfunction

endpackage

// File: rtl/temporizador_puerta_if.sv
// temporizador_puerta_if: control/status bundle between the door FSM (master)
// and the door-open timer (slave).
//   startTimer, rearm, hold, cancel : master -> slave controls
//   C_1Hz, busy, segundos, timeExpired, expired_pulse : slave -> master status
//   aviso : pre-expiry warning, present only when TEMPORIZADOR_AVISO_EN is defined
interface temporizador_puerta_if #(
  parameter int SEC_W = 8
);
  logic             startTimer;
  logic             rearm;
  logic             hold;
  logic             cancel;
  logic             C_1Hz;
  logic             busy;
  logic [SEC_W-1:0] segundos;
  logic             timeExpired;
  logic             expired_pulse;
`ifdef TEMPORIZADOR_AVISO_EN
  logic             aviso;

  modport master (
    output startTimer, rearm, hold, cancel,
    input  C_1Hz, busy, segundos, timeExpired, expired_pulse, aviso
  );
  modport slave (
    input  startTimer, rearm, hold, cancel,
    output C_1Hz, busy, segundos, timeExpired, expired_pulse, aviso
  );
`else
  modport master (
    output startTimer, rearm, hold, cancel,
    input  C_1Hz, busy, segundos, timeExpired, expired_pulse
  );
  modport slave (
    input  startTimer, rearm, hold, cancel,
    output C_1Hz, busy, segundos, timeExpired, expired_pulse
  );
`endif
endinterface

// File: rtl/temporizador_puerta_divisor_tick.sv
// divisor_tick: prescaler counting 0..DIV-1 while enabled.
//   clk, restart : clock and asynchronous active-high reset
//   enable       : advance the count this cycle
//   clear        : force the count to 0 (wins over enable)
//   tick         : count is at DIV-1, i.e. an enabled cycle now wraps
//   phase        : 0 for the first half of the period, 1 for the second
module divisor_tick
  import temporizador_pkg::*;
#(
  parameter int DIV = 100000000
) (
  input  logic clk,
  input  logic restart,
  input  logic enable,
  input  logic clear,
  output logic tick,
  output logic phase
);
  localparam int W = presc_width(DIV);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // tick is deliberately not gated by enable so the caller can combine it
  // with its own enable term without creating a combinational loop.
  assign tick  = (count_reg == W'(DIV - 1));
  assign phase = (count_reg >= W'(DIV / 2));

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = tick ? '0 : count_reg + W'(1);
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/temporizador_puerta.sv
// temporizador_puerta: door-open timer. Divides C_100Mhz down to a one-second
// tick, counts whole seconds up to TIMEOUT_S and flags expiry.
//   C_100Mhz : system clock
//   restart  : asynchronous active-high reset
//   bus      : slave side of temporizador_puerta_if (controls in, status out)
// Optional feature: define TEMPORIZADOR_AVISO_EN to add the `aviso` warning,
// raised WARN_S seconds before timeout while the run is active.
module temporizador_puerta
  import temporizador_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int TIMEOUT_S = 10,
  parameter int SEC_W     = 8,
  parameter int WARN_S    = 2
) (
  input  logic                  C_100Mhz,
  input  logic                  restart,
  temporizador_puerta_if.slave  bus
);
  if ((CLK_HZ < 4) || ((CLK_HZ % 2) != 0)) begin : g_bad_clk
    $error("temporizador_puerta: CLK_HZ must be even and >= 4");
  end
  if ((TIMEOUT_S < 1) || (TIMEOUT_S >= (1 << SEC_W))) begin : g_bad_timeout
    $error("temporizador_puerta: TIMEOUT_S out of range for SEC_W");
  end
  if ((WARN_S < 1) || (WARN_S >= TIMEOUT_S)) begin : g_bad_warn
    $error("temporizador_puerta: WARN_S must satisfy 1 <= WARN_S < TIMEOUT_S");
  end

  estado_t          state_reg, state_next;
  logic [SEC_W-1:0] seg_reg, seg_next;
  logic             pulse_reg, pulse_next;
  logic             presc_en, presc_clear;
  logic             tick, phase;
  logic             active;

  divisor_tick #(.DIV(CLK_HZ)) u_divisor (
    .clk     (C_100Mhz),
    .restart (restart),
    .enable  (presc_en),
    .clear   (presc_clear),
    .tick    (tick),
    .phase   (phase)
  );

  // Priority: cancel > startTimer > rearm > hold > tick.
  always_comb begin
    state_next  = state_reg;
    seg_next    = seg_reg;
    pulse_next  = 1'b0;
    presc_en    = 1'b0;
    presc_clear = 1'b0;
    if (bus.cancel) begin
      state_next  = ST_IDLE;
      seg_next    = '0;
      presc_clear = 1'b1;
    end else if (bus.startTimer) begin
      state_next  = ST_RUNNING;
      seg_next    = '0;
      presc_clear = 1'b1;
    end else begin
      case (state_reg)
        ST_RUNNING, ST_PAUSED: begin
          if (bus.rearm) begin
            // State is left as is; only the run restarts from zero.
            seg_next    = '0;
            presc_clear = 1'b1;
          end else if (bus.hold) begin
            state_next = ST_PAUSED;
          end else begin
            // The cycle that leaves PAUSED already counts, so each paused
            // cycle delays expiry by exactly one cycle.
            state_next = ST_RUNNING;
            presc_en   = 1'b1;
            if (tick) begin
              if (seg_reg == SEC_W'(TIMEOUT_S - 1)) begin
                state_next = ST_EXPIRED;
                pulse_next = 1'b1;
              end
              seg_next = seg_reg + SEC_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge C_100Mhz or posedge restart) begin
    if (restart) begin
      state_reg <= ST_IDLE;
      seg_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      seg_reg   <= seg_next;
      pulse_reg <= pulse_next;
    end
  end

  // All status is decoded straight from registers; no input reaches an
  // output combinationally.
  assign active            = (state_reg == ST_RUNNING) || (state_reg == ST_PAUSED);
  assign bus.busy          = active;
  assign bus.segundos      = seg_reg;
  assign bus.C_1Hz         = active && phase;
  assign bus.timeExpired   = (state_reg == ST_EXPIRED);
  assign bus.expired_pulse = pulse_reg;

`ifdef TEMPORIZADOR_AVISO_EN
  assign bus.aviso = active && (seg_reg >= SEC_W'(TIMEOUT_S - WARN_S));
`endif
endmodule

// File: tb/tb_temporizador_puerta.sv
module tb_temporizador_puerta;
  localparam int CLK_HZ    = 10;
  localparam int TIMEOUT_S = 3;
  localparam int SEC_W     = 4;
  localparam int WARN_S    = 1;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  // reference model: mode 0 idle, 1 active (running or paused), 2 expired;
  // m_e counts cycles elapsed in the run, everything else derives from it
  int   m_mode;
  int   m_e;
  bit   m_pulse;

  temporizador_puerta_if #(.SEC_W(SEC_W)) bus ();

  temporizador_puerta #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_S (TIMEOUT_S),
    .SEC_W     (SEC_W),
    .WARN_S    (WARN_S)
  ) dut (
    .C_100Mhz (clk),
    .restart  (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_e     = 0;
    m_pulse = 0;
  endtask

  task automatic model_edge();
    m_pulse = 0;
    if (bus.cancel) begin
      m_mode = 0; m_e = 0;
    end else if (bus.startTimer) begin
      m_mode = 1; m_e = 0;
    end else if (m_mode == 1) begin
      if (bus.rearm) m_e = 0;
      else if (!bus.hold) begin
        m_e++;
        if (m_e == TIMEOUT_S * CLK_HZ) begin
          m_mode = 2; m_pulse = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    int seg;
    seg = (m_mode == 0) ? 0 : (m_mode == 2) ? TIMEOUT_S : m_e / CLK_HZ;
    chk("busy", 32'(bus.busy), 32'(m_mode == 1));
    chk("segundos", 32'(bus.segundos), 32'(seg));
    chk("C_1Hz", 32'(bus.C_1Hz), 32'((m_mode == 1) && ((m_e % CLK_HZ) >= CLK_HZ / 2)));
    chk("timeExpired", 32'(bus.timeExpired), 32'(m_mode == 2));
    chk("expired_pulse", 32'(bus.expired_pulse), 32'(m_pulse));
`ifdef TEMPORIZADOR_AVISO_EN
    chk("aviso", 32'(bus.aviso), 32'((m_mode == 1) && (seg >= TIMEOUT_S - WARN_S)));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // single-cycle start; leaves inputs idle afterwards
  task automatic start_run();
    bus.startTimer = 1'b1;
    step();
    bus.startTimer = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.startTimer = 1'b0;
    bus.rearm      = 1'b0;
    bus.hold       = 1'b0;
    bus.cancel     = 1'b0;

    // reset and idle
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 50; i++) step();
    chk("idle_segundos", 32'(bus.segundos), 32'd0);
    $display("reset + idle 50 cycles done");

    // uninterrupted run
    start_run();
    chk("start_busy", 32'(bus.busy), 32'd1);
    for (int n = 1; n <= 31; n++) begin
      step();
      if (n == 4)  chk("c1hz_low_at_4", 32'(bus.C_1Hz), 32'd0);
      if (n == 5)  chk("c1hz_high_at_5", 32'(bus.C_1Hz), 32'd1);
      if (n == 10) chk("seg1_at_10", 32'(bus.segundos), 32'd1);
      if (n == 20) chk("seg2_at_20", 32'(bus.segundos), 32'd2);
`ifdef TEMPORIZADOR_AVISO_EN
      if (n == 19) chk("aviso_low_at_19", 32'(bus.aviso), 32'd0);
      if (n == 20) chk("aviso_high_at_20", 32'(bus.aviso), 32'd1);
      if (n == 30) chk("aviso_low_at_30", 32'(bus.aviso), 32'd0);
`endif
      if (n == 29) chk("not_expired_at_29", 32'(bus.timeExpired), 32'd0);
      if (n == 30) begin
        chk("expired_at_30", 32'(bus.timeExpired), 32'd1);
        chk("pulse_at_30", 32'(bus.expired_pulse), 32'd1);
        chk("seg3_at_30", 32'(bus.segundos), 32'd3);
      end
      if (n == 31) begin
        chk("pulse_low_at_31", 32'(bus.expired_pulse), 32'd0);
        chk("expired_hold_at_31", 32'(bus.timeExpired), 32'd1);
      end
    end
    $display("uninterrupted run done");

    // restart from EXPIRED, with hold over cycles 12..16
    start_run();
    chk("restart_from_expired_te", 32'(bus.timeExpired), 32'd0);
    for (int n = 1; n <= 35; n++) begin
      bus.hold = (n >= 12 && n <= 16);
      step();
      if (n == 16) chk("seg_frozen_in_hold", 32'(bus.segundos), 32'd1);
      if (n == 34) chk("hold_not_expired_34", 32'(bus.timeExpired), 32'd0);
      if (n == 35) chk("hold_expired_35", 32'(bus.timeExpired), 32'd1);
    end
    bus.hold = 1'b0;
    $display("hold run done");

    // rearm at cycle 25
    start_run();
    for (int n = 1; n <= 55; n++) begin
      bus.rearm = (n == 25);
      step();
      if (n == 24) chk("seg2_before_rearm", 32'(bus.segundos), 32'd2);
      if (n == 25) begin
        chk("rearm_seg0", 32'(bus.segundos), 32'd0);
        chk("rearm_busy", 32'(bus.busy), 32'd1);
      end
      if (n == 54) chk("rearm_not_expired_54", 32'(bus.timeExpired), 32'd0);
      if (n == 55) chk("rearm_expired_55", 32'(bus.timeExpired), 32'd1);
    end
    bus.rearm = 1'b0;
    $display("rearm run done");

    // cancel and start together while running
    start_run();
    for (int n = 0; n < 5; n++) step();
    bus.cancel = 1'b1;
    bus.startTimer = 1'b1;
    step();
    bus.cancel = 1'b0;
    bus.startTimer = 1'b0;
    chk("cancel_wins_busy", 32'(bus.busy), 32'd0);
    chk("cancel_wins_seg", 32'(bus.segundos), 32'd0);
    $display("cancel+start same cycle done");

    // asynchronous restart mid-run at cycle 17
    start_run();
    for (int n = 1; n <= 17; n++) step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    $display("async restart mid-run done");

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.startTimer = ($urandom_range(0, 99) < 3);
      bus.cancel     = ($urandom_range(0, 199) < 2);
      bus.rearm      = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 7) == 0) bus.hold = ~bus.hold;
      step();
    end
    bus.startTimer = 1'b0;
    bus.cancel     = 1'b0;
    bus.rearm      = 1'b0;
    bus.hold       = 1'b0;
    $display("random traffic 3000 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
